alu_result_stage: RTL and testbench

Registered writeback stage that sits directly downstream of the ALU execution units (multiplier, adder, logic). It captures each unit's result word and 4-bit status vector into a 2-entry skid FIFO with valid/ready handshakes on both sides. On commit it updates the architectural status register, keeps a sticky overflow flag, and keeps a saturating overflow event counter.

---
 rtl/alu_result_stage.sv | 148 ++++++++++++++
 tb/tb_alu_result_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Writeback stage behind the ALU units: a 2-entry skid FIFO plus commit-side status tracking.
// Latency: 1 cycle from a push edge to the entry appearing at the output; sustained 1 entry/cycle.
// Backpressure: in_ready is registered from the occupancy only and never follows out_ready in the same cycle.
module alu_result_stage #(
  parameter int WIDTH       = 16,
  parameter int ST_CARRY    = 0,
  parameter int ST_ZERO     = 1,
  parameter int ST_NEG      = 2,
  parameter int ST_OVERFLOW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_status,
  input  logic             in_update_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_status,
  output logic [3:0]       flags,
  output logic             sticky_ovf,
  output logic [7:0]       ovf_count,
  input  logic             clear_sticky
);

  // Status vectors are copied field by field; the stage never recomputes zero/negative.
  function automatic logic [3:0] pass_status(input logic [3:0] st);
    logic [3:0] r;
    r              = '0;
    r[ST_CARRY]    = st[ST_CARRY];
    r[ST_ZERO]     = st[ST_ZERO];
    r[ST_NEG]      = st[ST_NEG];
    r[ST_OVERFLOW] = st[ST_OVERFLOW];
    return r;
  endfunction

  logic [WIDTH-1:0] res_q [2];
  logic [3:0]       st_q  [2];
  logic             upd_q [2];

  logic       wptr_q, rptr_q;
  logic [1:0] count_q, count_d;
  logic       in_ready_q;
  logic [3:0] flags_q, flags_d;
  logic       sticky_q, sticky_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  logic       push, pop;
  logic       head_upd;
  logic [3:0] head_st;
  logic       commit_flags, ovf_commit;

  // Handshakes, head decode and all next-state values.
  always_comb begin
    push         = in_valid & in_ready_q;
    pop          = (count_q != 2'd0) & out_ready;
    head_upd     = upd_q[rptr_q];
    head_st      = st_q[rptr_q];
    commit_flags = pop & head_upd;
    ovf_commit   = commit_flags & head_st[ST_OVERFLOW];

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    flags_d = commit_flags ? pass_status(head_st) : flags_q;

    // An overflow commit beats a simultaneous clear.
    sticky_d  = sticky_q;
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_commit) begin
      sticky_d = 1'b1;
      if (clear_sticky) begin
        ovf_cnt_d = 8'd1;
      end else if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end else if (clear_sticky) begin
      sticky_d  = 1'b0;
      ovf_cnt_d = 8'd0;
    end
  end

  // FIFO storage and pointers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q[0] <= '0;
      res_q[1] <= '0;
      st_q[0]  <= '0;
      st_q[1]  <= '0;
      upd_q[0] <= 1'b0;
      upd_q[1] <= 1'b0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        res_q[wptr_q] <= in_result;
        st_q[wptr_q]  <= pass_status(in_status);
        upd_q[wptr_q] <= in_update_flags;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_d;
    end
  end

  // in_ready is held low through reset and tracks the next occupancy afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (count_d != 2'd2);
    end
  end

  // Architectural status register and overflow tracking, updated on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= 4'd0;
      sticky_q  <= 1'b0;
      ovf_cnt_q <= 8'd0;
    end else begin
      flags_q   <= flags_d;
      sticky_q  <= sticky_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Outputs read zero whenever the FIFO is empty.
  always_comb begin
    in_ready   = in_ready_q;
    out_valid  = (count_q != 2'd0);
    out_result = out_valid ? res_q[rptr_q] : '0;
    out_status = out_valid ? st_q[rptr_q] : 4'd0;
    flags      = flags_q;
    sticky_ovf = sticky_q;
    ovf_count  = ovf_cnt_q;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_result = '0;
  logic [3:0]   in_status = '0;
  logic         in_update_flags = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic [3:0]   out_status;
  logic [3:0]   flags;
  logic         sticky_ovf;
  logic [7:0]   ovf_count;
  logic         clear_sticky = 1'b0;

  alu_result_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_status(in_status), .in_update_flags(in_update_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_status(out_status),
    .flags(flags), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count),
    .clear_sticky(clear_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted entries plus the architectural state.
  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   st;
    logic         upd;
  } ent_t;

  ent_t     mq[$];
  logic     m_rdy = 1'b0;
  logic [3:0] m_flags = '0;
  logic     m_sticky = 1'b0;
  int       m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rdy = 1'b0; m_flags = '0; m_sticky = 1'b0; m_cnt = 0;
    end else begin
      bit do_push, do_pop, ovf;
      ent_t e;
      do_push = in_valid && m_rdy;
      do_pop  = (mq.size() > 0) && out_ready;
      ovf = 1'b0;
      if (do_pop) begin
        e = mq.pop_front();
        if (e.upd) begin
          m_flags = e.st;
          ovf = e.st[3];
        end
      end
      if (ovf) begin
        m_sticky = 1'b1;
        m_cnt = clear_sticky ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (clear_sticky) begin
        m_sticky = 1'b0;
        m_cnt = 0;
      end
      if (do_push) mq.push_back('{res: in_result, st: in_status, upd: in_update_flags});
      m_rdy = (mq.size() < 2);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_result", out_result, (mq.size() != 0) ? mq[0].res : '0);
    chk("out_status", out_status, (mq.size() != 0) ? mq[0].st : '0);
    chk("flags", flags, m_flags);
    chk("sticky_ovf", sticky_ovf, m_sticky);
    chk("ovf_count", ovf_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one entry and holds it until the stage accepts it.
  task automatic push(input logic [W-1:0] r, input logic [3:0] s, input logic u);
    bit acc;
    in_valid = 1'b1; in_result = r; in_status = s; in_update_flags = u;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("push_timeout", 1, 0);
  endtask

  initial begin
    // Reset with in_valid asserted.
    in_valid = 1'b1; in_result = 16'hDEAD;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_ovf_count", ovf_count, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", in_ready, 0);
    tick();
    chk("rel_in_ready_high", in_ready, 1);

    // Single pass.
    out_ready = 1'b1;
    push(16'h0012, 4'b0000, 1'b1);
    chk("single_valid", out_valid, 1);
    chk("single_result", out_result, 16'h0012);
    tick();
    chk("single_drained", out_valid, 0);
    chk("single_flags", flags, 4'b0000);
    chk("single_sticky", sticky_ovf, 0);

    // Backpressure.
    out_ready = 1'b0;
    push(16'h1111, 4'b0001, 1'b0);
    push(16'h2222, 4'b0010, 1'b0);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_result = 16'h3333; in_status = 4'b0100; in_update_flags = 1'b0;
    repeat (3) tick();
    chk("held_head", out_result, 16'h1111);
    chk("held_in_ready", in_ready, 0);
    out_ready = 1'b1;
    push(16'h3333, 4'b0100, 1'b0);
    repeat (3) tick();
    chk("bp_drained", out_valid, 0);

    // Streaming at one entry per cycle.
    for (int i = 0; i < 20; i++) push(16'h0100 + 16'(i), 4'(i), 1'b0);
    repeat (2) tick();

    // Overflow tracking and clear/set collision.
    push(16'h0005, 4'b1000, 1'b1);
    tick();
    chk("ovf_sticky", sticky_ovf, 1);
    chk("ovf_count1", ovf_count, 1);
    chk("ovf_flags", flags, 4'b1000);
    push(16'h0006, 4'b1000, 1'b0);
    tick();
    chk("noupd_flags", flags, 4'b1000);
    chk("noupd_count", ovf_count, 1);
    push(16'h0007, 4'b1001, 1'b1);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("clr_set_sticky", sticky_ovf, 1);
    chk("clr_set_count", ovf_count, 1);
    chk("clr_set_flags", flags, 4'b1001);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("clr_sticky", sticky_ovf, 0);
    chk("clr_count", ovf_count, 0);

    // Randomised traffic with upstream holding unaccepted offers.
    begin
      bit acc;
      acc = 1'b1;
      for (int c = 0; c < 600; c++) begin
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_result = W'($urandom);
          in_status = 4'($urandom);
          in_update_flags = $urandom_range(0, 1);
        end
        out_ready = ($urandom_range(0, 3) != 0);
        clear_sticky = ($urandom_range(0, 40) == 0);
        acc = in_valid && in_ready;
        tick();
      end
      in_valid = 1'b0; clear_sticky = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
    end

    // Saturation.
    for (int i = 0; i < 260; i++) push(16'(i), 4'b1000, 1'b1);
    repeat (2) tick();
    chk("sat_count", ovf_count, 255);

    // Asynchronous reset with two entries queued.
    out_ready = 1'b0;
    push(16'hAAAA, 4'b0011, 1'b1);
    push(16'hBBBB, 4'b1000, 1'b1);
    chk("queued_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ovf_count", ovf_count, 0);
    chk("arst_flags", flags, 0);
    chk("arst_in_ready", in_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    push(16'h4242, 4'b0101, 1'b1);
    tick();
    chk("post_rst_flags", flags, 4'b0101);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
